// File: rtl/demux_seq_defs.sv
// Shared constants for the demux channel sequencer: FSM encodings,
// channel count, default settle interval and a one-hot helper.
package demux_seq_defs;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;

    localparam int NCH            = 4;
    localparam int SETTLE_CYC_DEF = 2;

    // Latch enable for one channel.
    function automatic logic [NCH-1:0] chan_onehot(input logic [1:0] ch);
        return {{(NCH-1){1'b0}}, 1'b1} << ch;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle interval timer. Counts cycles while en is high, saturating at
// SETTLE_CYC. expired is high during the last settle cycle, so the owner
// can leave SETTLE on that edge.
module settle_timer #(
    parameter int CNT_W      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SETTLE_CYC);

    logic [CNT_W-1:0] cnt;

    // Cycle counter: clear has priority, then count up and hold at FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != FULL)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/demux_channel_sequencer.sv
// Drives a 1-to-4 demux: takes a 4-bit word, then for channels 0..3 holds
// sel/din for SETTLE_CYC cycles and emits one strobe cycle with a one-hot
// latch enable. Every output is a register.
//
// Handshake: a word is consumed on a cycle where in_valid && in_ready.
// in_ready is high exactly when the FSM is IDLE; a producer presenting
// in_valid while busy keeps its word, it is not dropped.
module demux_channel_sequencer
    import demux_seq_defs::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           flush,
    output logic [1:0]     sel,
    output logic           din,
    output logic           strobe,
    output logic [NCH-1:0] chan_en,
    output logic           done,
    output logic           busy
);

    logic [1:0]     state_q, state_d;
    logic [1:0]     ch_q, ch_d;
    logic [NCH-1:0] word_q, word_d;
    logic [1:0]     sel_d;
    logic           din_d;
    logic           strobe_d;
    logic [NCH-1:0] chan_en_d;
    logic           done_d;
    logic           expired;

    settle_timer #(
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != S_SETTLE),
        .en      (state_q == S_SETTLE),
        .expired (expired)
    );

    // Next-state and next-output logic; sel/din only move when a SETTLE
    // window starts or the FSM returns to IDLE, never with a strobe.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        word_d    = word_q;
        sel_d     = sel;
        din_d     = din;
        strobe_d  = 1'b0;
        chan_en_d = '0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                sel_d = 2'd0;
                din_d = 1'b0;
                // Accept wins over a simultaneous flush.
                if (in_valid && in_ready) begin
                    state_d = S_SETTLE;
                    ch_d    = 2'd0;
                    word_d  = in_data;
                    din_d   = in_data[0];
                end
            end
            S_SETTLE: begin
                if (flush) begin
                    state_d = S_IDLE;
                    ch_d    = 2'd0;
                    word_d  = '0;
                    sel_d   = 2'd0;
                    din_d   = 1'b0;
                end else if (expired) begin
                    state_d   = S_STROBE;
                    strobe_d  = 1'b1;
                    chan_en_d = chan_onehot(ch_q);
                    done_d    = (ch_q == 2'd3);
                end
            end
            S_STROBE: begin
                // ch==3 ends the word here instead of letting ch wrap.
                if (flush || (ch_q == 2'd3)) begin
                    state_d = S_IDLE;
                    ch_d    = 2'd0;
                    word_d  = '0;
                    sel_d   = 2'd0;
                    din_d   = 1'b0;
                end else begin
                    state_d = S_SETTLE;
                    ch_d    = ch_q + 2'd1;
                    sel_d   = ch_d;
                    din_d   = word_q[ch_d];
                end
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = 2'd0;
                word_d  = '0;
                sel_d   = 2'd0;
                din_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset lands in IDLE with in_ready high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ch_q     <= 2'd0;
            word_q   <= '0;
            sel      <= 2'd0;
            din      <= 1'b0;
            strobe   <= 1'b0;
            chan_en  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            word_q   <= word_d;
            sel      <= sel_d;
            din      <= din_d;
            strobe   <= strobe_d;
            chan_en  <= chan_en_d;
            done     <= done_d;
            busy     <= (state_d != S_IDLE);
            in_ready <= (state_d == S_IDLE);
        end
    end

endmodule

// File: tb/tb_demux_channel_sequencer.sv
// Directed bench: instance a with SETTLE_CYC=2, instance b with SETTLE_CYC=1.
// A downstream demux+latch model per instance feeds a word scoreboard.
module tb_demux_channel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       flush_a, flush_b;
    logic       in_ready_a, in_ready_b;
    logic [1:0] sel_a, sel_b;
    logic       din_a, din_b;
    logic       strobe_a, strobe_b;
    logic [3:0] chan_en_a, chan_en_b;
    logic       done_a, done_b;
    logic       busy_a, busy_b;

    int         n_vec = 0;
    int         n_err = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_q_b[$];
    logic [3:0] lat_a;
    logic [3:0] lat_b;

    // clock
    always #5 clk = ~clk;

    demux_channel_sequencer #(.SETTLE_CYC(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .flush(flush_a), .sel(sel_a), .din(din_a),
        .strobe(strobe_a), .chan_en(chan_en_a), .done(done_a), .busy(busy_a)
    );

    demux_channel_sequencer #(.SETTLE_CYC(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .flush(flush_b), .sel(sel_b), .din(din_b),
        .strobe(strobe_b), .chan_en(chan_en_b), .done(done_b), .busy(busy_b)
    );

    // Output bundle: {sel, din, strobe, chan_en, done, busy, in_ready}
    function automatic logic [15:0] pk(input logic [1:0] s, input logic d,
                                       input logic st, input logic [3:0] en,
                                       input logic dn, input logic bz,
                                       input logic rdy);
        return {5'b0, s, d, st, en, dn, bz, rdy};
    endfunction

    function automatic logic [15:0] obs(input bit use_b);
        if (use_b)
            return pk(sel_b, din_b, strobe_b, chan_en_b, done_b, busy_b, in_ready_b);
        return pk(sel_a, din_a, strobe_a, chan_en_a, done_a, busy_a, in_ready_a);
    endfunction

    function automatic logic [15:0] idle_v();
        return pk(2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample after the edge, run latch model and scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (chan_en_a[k]) lat_a[k] = (sel_a == 2'(k)) ? din_a : 1'b0;
            if (chan_en_b[k]) lat_b[k] = (sel_b == 2'(k)) ? din_b : 1'b0;
        end
        if (done_a) begin
            if (exp_q.size() == 0) chk("a_unexpected_done", 16'd1, 16'd0);
            else chk("a_latch_word", {12'b0, lat_a}, {12'b0, exp_q.pop_front()});
        end
        if (done_b) begin
            if (exp_q_b.size() == 0) chk("b_unexpected_done", 16'd1, 16'd0);
            else chk("b_latch_word", {12'b0, lat_b}, {12'b0, exp_q_b.pop_front()});
        end
    endtask

    // Cycle c (1-based, c=1 is the cycle after the accept edge) of a word:
    // channel (c-1)/(s+1), strobe on the last cycle of each channel window.
    task automatic check_word(input bit use_b, input logic [3:0] w, input int s,
                              input int last_c, input string tag);
        int          ch;
        logic        st;
        logic [15:0] e;
        for (int c = 1; c <= last_c; c++) begin
            if (c > 1) tick();
            ch = (c - 1) / (s + 1);
            st = ((c % (s + 1)) == 0);
            e  = pk(2'(ch), w[ch], st, st ? (4'b0001 << ch) : 4'b0000,
                    st && (ch == 3), 1'b1, 1'b0);
            chk($sformatf("%s_c%0d", tag, c), obs(use_b), e);
        end
    endtask

    initial begin
        in_data_a = 4'b0; in_valid_a = 1'b0; flush_a = 1'b0;
        in_data_b = 4'b0; in_valid_b = 1'b0; flush_b = 1'b0;
        lat_a = 4'b0000;
        lat_b = 4'b1111;

        // reset state
        tick();
        chk("a_reset", obs(1'b0), idle_v());
        chk("b_reset", obs(1'b1), idle_v());
        rst_n = 1'b1;
        tick();
        chk("a_idle", obs(1'b0), idle_v());

        // word 1011, then 0110 presented while busy and held
        in_data_a = 4'b1011; in_valid_a = 1'b1;
        exp_q.push_back(4'b1011);
        tick();
        in_data_a = 4'b0110;
        check_word(1'b0, 4'b1011, 2, 12, "w1");
        tick();
        chk("w1_c13_ready", obs(1'b0), idle_v());
        exp_q.push_back(4'b0110);
        tick();
        in_valid_a = 1'b0;
        check_word(1'b0, 4'b0110, 2, 12, "w2");
        tick();
        chk("w2_end_idle", obs(1'b0), idle_v());

        // flush while idle does nothing
        flush_a = 1'b1;
        tick();
        chk("flush_idle", obs(1'b0), idle_v());
        flush_a = 1'b0;

        // flush during channel 1 settle (cycle 5)
        in_data_a = 4'b1111; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        check_word(1'b0, 4'b1111, 2, 5, "fl");
        flush_a = 1'b1;
        tick();
        chk("fl_c6", obs(1'b0), idle_v());
        flush_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fl_quiet%0d", i), obs(1'b0), idle_v());
        end

        // asynchronous reset at cycle 7
        in_data_a = 4'b0101; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        check_word(1'b0, 4'b0101, 2, 7, "rs");
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async", obs(1'b0), idle_v());
        tick();
        chk("rs_held", obs(1'b0), idle_v());
        #2 rst_n = 1'b1;
        tick();
        chk("rs_idle", obs(1'b0), idle_v());

        // SETTLE_CYC=1, word 0000, accepted together with flush
        in_data_b = 4'b0000; in_valid_b = 1'b1; flush_b = 1'b1;
        exp_q_b.push_back(4'b0000);
        tick();
        in_valid_b = 1'b0; flush_b = 1'b0;
        check_word(1'b1, 4'b0000, 1, 8, "b");
        tick();
        chk("b_end_idle", obs(1'b1), idle_v());

        chk("a_sb_left", 16'(exp_q.size()), 16'd0);
        chk("b_sb_left", 16'(exp_q_b.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
